prefetch_queue: RTL
===================

// Module: prefetch_queue
// PURPOSE
//  Instruction prefetch queue feeding the pre-decoder. Issues 16-bit code fetches at PS:PC to the bus unit.
//  Buffers up to DEPTH opcode bytes and presents the head bytes plus their count and PC to pre-decode.
//  Pre-decode retires bytes through consume, once per decoded pre_decode_t of pre_size bytes.
//  Execute redirects the stream (branch, call, return, interrupt) with flush.
// PARAMETERS
//  DEPTH   6   queue capacity in bytes, range 4..8
//  PEEK    6   head bytes presented on q_data, must be <= DEPTH
// PORTS
//  clk         in   1        core clock; all state changes on its rising edge
//  reset       in   1        asynchronous, active-high
//  flush       in   1        discard the queue and restart fetching at flush_ps:flush_pc
//  flush_ps    in   16       new PS value
//  flush_pc    in   16       new PC value
//  fetch_req   out  1        code fetch request; held until fetch_ack
//  fetch_addr  out  20       physical address ((PS<<4)+PC) mod 2^20; stable while fetch_req=1
//  fetch_ack   in   1        fetch_data is valid this cycle; ends the request
//  fetch_data  in   16       bus word; [7:0] is the even byte, [15:8] is the odd byte
//  q_data      out  8*PEEK   head bytes; byte i at [8i+7:8i]; byte 0 is the oldest
//  q_count     out  4        number of valid bytes in the queue, 0..DEPTH
//  q_pc        out  16       PC of byte 0
//  consume     in   4        bytes to retire this cycle, 0..q_count
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset is asynchronous and active-high.
//  Reset values:
//   - fetch_req=0, fetch_addr=0, q_data=0, q_count=0, q_pc=0
//   - internal PS=16'hFFFF, fetch PC=0, discard=0
//   - first request after reset is at 20'hFFFF0.
//  Fetch sizing:
//   - PC even: 2 bytes taken from the word, PC advances by 2.
//   - PC odd: 1 byte taken from fetch_data[15:8], PC advances by 1.
//   - PC wraps mod 2^16 within PS; PS is never incremented.
//  Request issue (registered):
//   - fetch_req rises on the edge after a cycle in which all hold: no request outstanding, flush=0, and free >= fetch size.
//   - free = DEPTH - (q_count - consume + bytes accepted this cycle).
//   - fetch_addr is registered together with fetch_req.
//   - Earliest re-issue is the cycle after an ack; no back-to-back requests on the same edge.
//  Accept:
//   - On fetch_ack with discard=0, bytes are appended at the tail.
//   - They are visible in q_count and q_data on the next cycle (1-cycle latency).
//  Consume:
//   - q_count and q_pc update on the next edge; q_pc += consume mod 2^16.
//   - Remaining bytes shift toward byte 0.
//   - consume > q_count is illegal: the bench asserts on it; RTL clamps to q_count.
//  Simultaneous consume and accept in one cycle:
//   - Both apply; new count = q_count - consume + accepted.
//   - Never exceeds DEPTH, guaranteed by the issue rule.
//  q_data bytes at index >= q_count are don't-care; the bench must not check them.
//  Flush, applied on the next edge:
//   - q_count=0, q_pc=flush_pc.
//   - Fetch pointer becomes flush_ps:flush_pc.
//   - consume and any same-cycle fetch_ack data are ignored.
//  Flush with a request outstanding and no ack in that cycle:
//   - fetch_req stays high with the old address until ack; the bus cycle cannot be aborted.
//   - discard is set; the returning data is dropped and discard clears.
//   - The new-stream request issues the cycle after that ack.
//  Repeated flushes while discard=1: only the last flush_ps:flush_pc is kept; one ack still clears discard.
//  Reset mid-request: everything returns to reset values immediately; the bus unit is reset by the same signal.
// TESTING
//  T1 reset release, ack after 2 cycles with data 16'hBBAA:
//     -> fetch_addr=20'hFFFF0; q_count=2; q_data[15:0]=16'hBBAA; q_pc=0.
//  T2 flush PS=16'h1000, PC=16'h0101, then acks:
//     -> first addr 20'h10101 takes 1 byte (data[15:8]); next addr 20'h10102 takes 2 bytes; q_count=3.
//  T3 no consume, acks every cycle:
//     -> q_count fills 2, 4, 6, then fetch_req stays low.
//     -> consume=1 keeps it low (free=1); a further consume=1 makes fetch_req rise on the next edge.
//  T4 flush while fetch_req=1 without ack; ack arrives 3 cycles later:
//     -> that data is dropped, q_count stays 0; the next fetch_addr equals the flush target.
//  T5 PS=0, PC=16'hFFFE, 4 acks:
//     -> addrs 20'h0FFFE, 20'h00000, 20'h00002, 20'h00004.
//     -> q_pc wraps FFFE -> 0000 as bytes are consumed.
//  T6 q_count=4, consume=3 and an ack of 2 bytes in the same cycle:
//     -> q_count=3; old byte 3 is now byte 0, followed by the 2 new bytes.

Source files
------------

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues code fetches at PS:PC, buffers opcode bytes and
// presents the head of the stream to pre-decode.
module prefetch_queue #(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned PEEK  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [15:0]       flush_ps,
    input  logic [15:0]       flush_pc,
    output logic              fetch_req,
    output logic [19:0]       fetch_addr,
    input  logic              fetch_ack,
    input  logic [15:0]       fetch_data,
    output logic [8*PEEK-1:0] q_data,
    output logic [3:0]        q_count,
    output logic [15:0]       q_pc,
    input  logic [3:0]        consume
);

    localparam int unsigned QW = 8 * DEPTH;

    logic [QW-1:0] q_buf, q_buf_n, shifted;
    logic [3:0]    cnt_n, cons, rem, acc_n, free_n, fsize;
    logic [15:0]   q_pc_n, ps, ps_n, fpc, fpc_n;
    logic [19:0]   fetch_addr_n;
    logic          discard, discard_n, fetch_req_n;
    logic          accept, two;
    logic [7:0]    byte0, byte1;

    // Next-state: retire, append, then decide whether a new fetch may issue.
    always_comb begin
        cons         = (consume > q_count) ? q_count : consume;
        rem          = q_count - cons;
        two          = ~fpc[0];
        fsize        = two ? 4'd2 : 4'd1;
        accept       = fetch_req & fetch_ack & ~discard & ~flush;
        acc_n        = accept ? fsize : 4'd0;
        byte0        = two ? fetch_data[7:0] : fetch_data[15:8];
        byte1        = fetch_data[15:8];
        shifted      = q_buf >> {cons, 3'b000};
        q_buf_n      = shifted;
        cnt_n        = rem + acc_n;
        free_n       = 4'(DEPTH) - cnt_n;
        q_pc_n       = q_pc + {12'd0, cons};
        ps_n         = ps;
        fpc_n        = accept ? (fpc + {12'd0, fsize}) : fpc;
        discard_n    = discard;
        fetch_req_n  = fetch_req;
        fetch_addr_n = fetch_addr;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (accept && 4'(i) == rem)
                q_buf_n[8*i +: 8] = byte0;
            if (accept && two && 4'(i) == rem + 4'd1)
                q_buf_n[8*i +: 8] = byte1;
        end

        // An ack always ends the bus cycle; a discarded one just drops its data.
        if (fetch_req && fetch_ack) begin
            discard_n   = 1'b0;
            fetch_req_n = 1'b0;
        end

        if (flush) begin
            cnt_n     = 4'd0;
            q_pc_n    = flush_pc;
            ps_n      = flush_ps;
            fpc_n     = flush_pc;
            discard_n = fetch_req & ~fetch_ack;
        end else if (!fetch_req && free_n >= fsize) begin
            fetch_req_n  = 1'b1;
            fetch_addr_n = {ps, 4'h0} + {4'h0, fpc};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_buf      <= '0;
            q_count    <= 4'd0;
            q_pc       <= 16'd0;
            ps         <= 16'hFFFF;
            fpc        <= 16'd0;
            discard    <= 1'b0;
            fetch_req  <= 1'b0;
            fetch_addr <= 20'd0;
        end else begin
            q_buf      <= q_buf_n;
            q_count    <= cnt_n;
            q_pc       <= q_pc_n;
            ps         <= ps_n;
            fpc        <= fpc_n;
            discard    <= discard_n;
            fetch_req  <= fetch_req_n;
            fetch_addr <= fetch_addr_n;
        end
    end

    assign q_data = q_buf[8*PEEK-1:0];

endmodule
